// File: rtl/lrelu_beats_sched_if.sv
// Handshake bundle between the LReLU beat scheduler and its environment.
// With LRELU_SCHED_LAST_CHECK_EN defined, the upstream stream also carries s_last.
interface lrelu_beats_sched_if #(
  parameter int KH_MAX      = 3,
  parameter int KW_MAX      = 3,
  parameter int BITS_BLOCKS = 16
);
  localparam int KH2_W = ($clog2((KH_MAX + 1) / 2) > 0) ? $clog2((KH_MAX + 1) / 2) : 1;
  localparam int KW2_W = ($clog2((KW_MAX + 1) / 2) > 0) ? $clog2((KW_MAX + 1) / 2) : 1;

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [KH2_W-1:0]       cfg_kh2;
  logic [KW2_W-1:0]       cfg_kw2;
  logic [BITS_BLOCKS-1:0] cfg_blocks_1;

  logic                   s_valid;
  logic                   s_ready;
`ifdef LRELU_SCHED_LAST_CHECK_EN
  logic                   s_last;
`endif

  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;

  logic                   cnt_en;
  logic                   cnt_clr;
  logic [KH2_W-1:0]       kh2_o;
  logic [KW2_W-1:0]       kw2_o;

  logic                   busy;
  logic                   done;
  logic                   err;

`ifdef LRELU_SCHED_LAST_CHECK_EN
  modport master (
    output cfg_valid, cfg_kh2, cfg_kw2, cfg_blocks_1, s_valid, s_last, m_ready,
    input  cfg_ready, s_ready, m_valid, m_last, cnt_en, cnt_clr, kh2_o, kw2_o,
           busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_kh2, cfg_kw2, cfg_blocks_1, s_valid, s_last, m_ready,
    output cfg_ready, s_ready, m_valid, m_last, cnt_en, cnt_clr, kh2_o, kw2_o,
           busy, done, err
  );
`else
  modport master (
    output cfg_valid, cfg_kh2, cfg_kw2, cfg_blocks_1, s_valid, m_ready,
    input  cfg_ready, s_ready, m_valid, m_last, cnt_en, cnt_clr, kh2_o, kw2_o,
           busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_kh2, cfg_kw2, cfg_blocks_1, s_valid, m_ready,
    output cfg_ready, s_ready, m_valid, m_last, cnt_en, cnt_clr, kh2_o, kw2_o,
           busy, done, err
  );
`endif

endinterface

// File: rtl/lrelu_beats_sched.sv
// Per-layer beat scheduler for the LReLU beats counter: header + data beats per block.
// Optional macro LRELU_SCHED_LAST_CHECK_EN adds an s_last cross-check that sets err.
module lrelu_beats_sched #(
  parameter int MEMBERS     = 12,
  parameter int KH_MAX      = 3,
  parameter int KW_MAX      = 3,
  parameter int BITS_BLOCKS = 16
) (
  input  logic               clk,
  input  logic               rst,
  lrelu_beats_sched_if.slave bus
);

  localparam int KH2_W   = ($clog2((KH_MAX + 1) / 2) > 0) ? $clog2((KH_MAX + 1) / 2) : 1;
  localparam int KW2_W   = ($clog2((KW_MAX + 1) / 2) > 0) ? $clog2((KW_MAX + 1) / 2) : 1;
  // Half-kernel ceilings, clipped to what the config field can actually hold.
  localparam int KH2_TOP = ((KH_MAX / 2) < (1 << KH2_W)) ? (KH_MAX / 2) : ((1 << KH2_W) - 1);
  localparam int KW2_TOP = ((KW_MAX / 2) < (1 << KW2_W)) ? (KW_MAX / 2) : ((1 << KW2_W) - 1);
  // kw2 = 0 gives the longest block: MEMBERS data beats plus the header.
  localparam int BEAT_W  = $clog2(MEMBERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 state;
  logic [KH2_W-1:0]       kh2_q;
  logic [KW2_W-1:0]       kw2_q;
  logic [BITS_BLOCKS-1:0] blocks_1_q;
  logic [BITS_BLOCKS-1:0] blk_cnt;
  logic [BEAT_W-1:0]      beats_1;
  logic [BEAT_W-1:0]      beat_cnt;
  logic                   err_q;
  logic                   done_q;
  logic                   clr_q;

  logic [KH2_W-1:0]       kh2_sat;
  logic [KW2_W-1:0]       kw2_sat;
  logic                   kh2_oor;
  logic                   kw2_oor;
  logic [BEAT_W-1:0]      beats_lut;

  logic                   in_run;
  logic                   fire;
  logic                   last_now;

  // NOTE: every variable gets a default before the loops so no latch can be inferred.
  always_comb begin
    kh2_sat = bus.cfg_kh2;
    kh2_oor = 1'b0;
    for (int v = KH2_TOP + 1; v < (1 << KH2_W); v++) begin
      if (bus.cfg_kh2 == KH2_W'(v)) begin
        kh2_sat = KH2_W'(KH2_TOP);
        kh2_oor = 1'b1;
      end
    end
  end

  always_comb begin
    kw2_sat = bus.cfg_kw2;
    kw2_oor = 1'b0;
    for (int v = KW2_TOP + 1; v < (1 << KW2_W); v++) begin
      if (bus.cfg_kw2 == KW2_W'(v)) begin
        kw2_sat = KW2_W'(KW2_TOP);
        kw2_oor = 1'b1;
      end
    end
  end

  // ceil(MEMBERS / (2*kw2+1)) as a constant table, avoiding a runtime divider.
  always_comb begin
    beats_lut = '0;
    for (int k = 0; k <= KW2_TOP; k++) begin
      if (kw2_q == KW2_W'(k)) beats_lut = BEAT_W'((MEMBERS + 2 * k) / (2 * k + 1));
    end
  end

  assign in_run   = (state == RUN);
  assign fire     = in_run && bus.s_valid && bus.m_ready;
  assign last_now = in_run && (beat_cnt == beats_1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kh2_q      <= '0;
      kw2_q      <= '0;
      blocks_1_q <= '0;
      blk_cnt    <= '0;
      beats_1    <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            kh2_q      <= kh2_sat;
            kw2_q      <= kw2_sat;
            blocks_1_q <= bus.cfg_blocks_1;
            blk_cnt    <= '0;
            beat_cnt   <= '0;
            clr_q      <= 1'b1;
            if (kh2_oor || kw2_oor) err_q <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          beats_1 <= beats_lut;
          state   <= RUN;
        end
        RUN: begin
          if (fire) begin
            if (last_now) begin
              beat_cnt <= '0;
              if (blk_cnt == blocks_1_q) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end else begin
                blk_cnt <= blk_cnt + 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
`ifdef LRELU_SCHED_LAST_CHECK_EN
            if (bus.s_last != last_now) err_q <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.m_valid   = in_run && bus.s_valid;
  assign bus.s_ready   = in_run && bus.m_ready;
  assign bus.cnt_en    = fire;
  assign bus.m_last    = last_now;
  assign bus.cnt_clr   = clr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.kh2_o     = kh2_q;
  assign bus.kw2_o     = kw2_q;

endmodule

// File: doc/lrelu_beats_sched.md
LRELU_BEATS_SCHED -- requirements
Module: lrelu_beats_sched

Interface
REQ-001 Parameter MEMBERS, default 12, output members per beat group.
REQ-002 Parameter KH_MAX, default 3, maximum kernel height.
REQ-003 Parameter KW_MAX, default 3, maximum kernel width.
REQ-004 Parameter BITS_BLOCKS, default 16, width of the block count.
REQ-005 Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid / cfg_ready  in / out  1  per-layer config handshake.
- cfg_kh2  in  clog2((KH_MAX+1)/2)  half kernel height.
- cfg_kw2  in  clog2((KW_MAX+1)/2)  half kernel width.
- cfg_blocks_1  in  BITS_BLOCKS  blocks in the layer minus one.
- s_valid / s_ready  in / out  1  upstream beat handshake.
- m_valid / m_ready  out / in  1  downstream beat handshake.
- m_last  out  1  last beat of the current block.
- cnt_en  out  1  enable to the LReLU beats counter.
- cnt_clr  out  1  one-cycle clear to the LReLU beats counter.
- kh2_o, kw2_o  out  as cfg  registered config to the counter.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse at layer end.
- err  out  1  sticky error flag.

Function
REQ-006 States: IDLE, LOAD, RUN.
REQ-007 cfg_ready SHALL be 1 only in IDLE; a cfg fire (cfg_valid & cfg_ready) SHALL capture cfg_kh2, cfg_kw2 and cfg_blocks_1 and move to LOAD.
REQ-008 LOAD SHALL last exactly one cycle, assert cnt_clr, register beats_1 = ceil(MEMBERS/(2*kw2+1)) (one header beat plus data beats, minus one), and move to RUN.
REQ-009 A cfg_kw2 above KW_MAX/2 or a cfg_kh2 above KH_MAX/2 SHALL be saturated to the maximum and SHALL set err.
REQ-010 In RUN: m_valid = s_valid, s_ready = m_ready. Outside RUN, m_valid, s_ready and cnt_en SHALL be 0.
REQ-011 A beat fires when s_valid & s_ready in RUN; cnt_en SHALL equal the fire combinationally, with zero latency.
REQ-012 beat_cnt SHALL increment on each fire; m_last SHALL be 1 while beat_cnt == beats_1; a fire with m_last SHALL wrap beat_cnt to 0 and increment blk_cnt.
REQ-013 A fire with m_last and blk_cnt == cfg_blocks_1 SHALL move to IDLE and pulse done in the next cycle.
REQ-014 Stalls (s_valid=0 or m_ready=0) SHALL hold all counters and outputs stable.
REQ-015 A cfg_valid asserted outside IDLE SHALL be ignored; it is not accepted until IDLE.
REQ-016 Counters SHALL be sized from beats_1 max (kw2=0) and BITS_BLOCKS, with no overflow inside the legal range.

Reset
REQ-017 rst SHALL force IDLE, beat_cnt=0, blk_cnt=0, kh2_o=0, kw2_o=0, err=0, done=0, cnt_clr=0; outputs then read cfg_ready=1, busy=0, m_valid=0, s_ready=0, cnt_en=0, m_last=0.
REQ-018 rst asserted mid-RUN SHALL abort the layer without a done pulse.

Configuration
REQ-019 Macro LRELU_SCHED_LAST_CHECK_EN: when defined, an input s_last (1 bit) SHALL exist; on a fire where s_last differs from m_last, err SHALL be set and held until rst. When undefined, the port and the check SHALL be absent, and err SHALL reflect only REQ-009.

Verification
REQ-020 MEMBERS=12, kw2=1, blocks_1=1, continuous valid/ready -> cnt_clr 1 cycle after the cfg fire; 10 fires; m_last on fires 5 and 10; done 1 cycle after fire 10.
REQ-021 kw2=0, blocks_1=0 -> 13 fires, m_last on fire 13 only, done follows, cfg_ready returns to 1.
REQ-022 Same as REQ-020 with m_ready toggled every cycle -> identical beat and m_last sequence, cnt_en high only on fire cycles.
REQ-023 rst held for 1 cycle after fire 3 of REQ-020 -> IDLE, no done, beat_cnt=0; a new cfg is accepted next cycle.
REQ-024 cfg_kw2 above KW_MAX/2 (out of range) -> err=1, kw2_o=1, beats_1=4.
REQ-025 With LRELU_SCHED_LAST_CHECK_EN, s_last=1 on fire 4 of REQ-020 -> err=1 from the next cycle, sticky until rst.
